// File: rtl/slink_stream_packer_if.sv
// slink_stream_packer_if -- stream bus bundle for slink_stream_packer.
//
// Carries both sides of the packer datapath:
//   data_i   [ElemWidth]        element from upstream
//   valid_i                     element valid
//   ready_o                     packer can take the element
//   data_o   [Width*ElemWidth]  packed word, slot k at [k*ElemWidth +: ElemWidth]
//   valid_o  [Width]            per-slot valid mask, contiguous from slot 0
//   ready_i                     downstream ready
// Modports: slave = packer side, master = environment driving it.
interface slink_stream_packer_if #(
  parameter int ElemWidth = 16,
  parameter int Width     = 32
);
  logic [ElemWidth-1:0]       data_i;
  logic                       valid_i;
  logic                       ready_o;
  logic [Width*ElemWidth-1:0] data_o;
  logic [Width-1:0]           valid_o;
  logic                       ready_i;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );
endinterface

// File: rtl/slink_stream_packer.sv
// slink_stream_packer -- packs a stream of ElemWidth-bit elements into words
// of Width slots. One fill buffer collects elements; a single output register
// presents a word with a contiguous slot-valid mask until downstream takes it.
// A word is emitted when the fill is full, on flush_i, or (optionally) after
// an idle timeout.
//
// Ports:
//   clk_i                   clock, rising edge
//   rst_i                   synchronous active-high reset
//   flush_i                 emit a partially filled word (no-op when empty)
//   cfg_auto_flush_en_i     enable idle-timeout flush
//   cfg_auto_flush_count_i  idle cycles before auto-flush (0 = first idle cycle)
//   bus (slave modport)     data_i/valid_i/ready_o in, data_o/valid_o/ready_i out
//
// Build option: define SLINK_PACKER_AUTO_FLUSH_EN to include the idle counter
// and auto-flush. Without it the cfg_auto_flush_* inputs are ignored.
module slink_stream_packer #(
  parameter int ElemWidth = 16,
  parameter int Width     = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       cfg_auto_flush_en_i,
  input  logic [5:0] cfg_auto_flush_count_i,
  slink_stream_packer_if.slave bus
);

  localparam int CntW = $clog2(Width + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Width);

  logic [ElemWidth-1:0]       fill_q [Width];
  logic [ElemWidth-1:0]       fill_d [Width];
  logic [CntW-1:0]            fill_cnt_q, fill_cnt_d;
  logic [Width*ElemWidth-1:0] data_q, data_d;
  logic [Width-1:0]           vld_q, vld_d;
  logic                       pend_q, pend_d;

  logic fill_full, fill_any, out_vld;
  logic accept, drain, auto_fire, emit_req, emit;

  assign fill_full = (fill_cnt_q == FullCnt);
  assign fill_any  = (fill_cnt_q != '0);
  assign out_vld   = |vld_q;
  assign drain     = out_vld && bus.ready_i;

`ifdef SLINK_PACKER_AUTO_FLUSH_EN
  logic [5:0] idle_q, idle_d;

  assign auto_fire = cfg_auto_flush_en_i && fill_any &&
                     (idle_q == cfg_auto_flush_count_i);

  // Counts cycles with a partial fill and no new element; saturates so a
  // long stall never wraps back onto the configured threshold.
  always_comb begin
    idle_d = idle_q;
    if (accept || emit) begin
      idle_d = '0;
    end else if (fill_any && (idle_q != 6'd63)) begin
      idle_d = idle_q + 6'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_auto_flush_en_i, cfg_auto_flush_count_i};
  assign auto_fire  = 1'b0;
`endif

  // An emit that could not land because the output register was occupied is
  // remembered in pend_q, so a one-cycle flush pulse is not lost.
  assign emit_req = fill_full || (flush_i && fill_any) || auto_fire || pend_q;
  assign emit     = emit_req && (!out_vld || bus.ready_i);

  // Only a full fill with nowhere to go blocks the input; when the fill moves
  // out this cycle the incoming element starts the next word in slot 0.
  assign bus.ready_o = !rst_i && (!fill_full || emit);
  assign accept      = bus.valid_i && bus.ready_o;

  always_comb begin
    fill_d     = fill_q;
    fill_cnt_d = fill_cnt_q;
    data_d     = data_q;
    vld_d      = vld_q;
    pend_d     = pend_q;

    if (drain) begin
      vld_d = '0;
    end

    if (emit) begin
      // Slots beyond the fill count may hold stale elements; zero them.
      for (int k = 0; k < Width; k++) begin
        vld_d[k]                       = (k < int'(fill_cnt_q));
        data_d[k*ElemWidth +: ElemWidth] = (k < int'(fill_cnt_q)) ? fill_q[k] : '0;
      end
      pend_d     = 1'b0;
      fill_cnt_d = '0;
    end else if (emit_req) begin
      pend_d = 1'b1;
    end

    if (accept) begin
      if (emit) begin
        fill_d[0]  = bus.data_i;
        fill_cnt_d = CntW'(1);
      end else begin
        for (int k = 0; k < Width; k++) begin
          if (k == int'(fill_cnt_q)) begin
            fill_d[k] = bus.data_i;
          end
        end
        fill_cnt_d = fill_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill_cnt_q <= '0;
      vld_q      <= '0;
      data_q     <= '0;
      pend_q     <= 1'b0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      vld_q      <= vld_d;
      data_q     <= data_d;
      pend_q     <= pend_d;
    end
  end

  // Fill slots are only ever read below fill_cnt, so they need no reset.
  always_ff @(posedge clk_i) begin
    fill_q <= fill_d;
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = vld_q;

endmodule

// File: tb/tb_slink_stream_packer.sv
// Directed bench for slink_stream_packer at Width=4, ElemWidth=16.
module tb_slink_stream_packer;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       af_en;
  logic [5:0] af_cnt;
  int         n_chk;
  int         n_fail;

  slink_stream_packer_if #(.ElemWidth(16), .Width(4)) bus ();

  slink_stream_packer #(.ElemWidth(16), .Width(4)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .flush_i                (flush),
    .cfg_auto_flush_en_i    (af_en),
    .cfg_auto_flush_count_i (af_cnt),
    .bus                    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    rst            = 1'b1;
    flush          = 1'b0;
    af_en          = 1'b0;
    af_cnt         = 6'd0;
    bus.data_i     = '0;
    bus.valid_i    = 1'b0;
    bus.ready_i    = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_valid", 64'(bus.valid_o), 64'h0);
    check("rst_data",  bus.data_o,       64'h0);
    check("rst_ready", 64'(bus.ready_o), 64'h0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(bus.ready_o), 64'h1);

    // Full-rate: eight elements, two words, no stall
    for (int i = 1; i <= 8; i++) begin
      bus.data_i  = 16'(i);
      bus.valid_i = 1'b1;
      #1;
      check("t1_ready", 64'(bus.ready_o), 64'h1);
      tick();
      if (i == 5) begin
        check("t1_w1_mask", 64'(bus.valid_o), 64'hF);
        check("t1_w1_data", bus.data_o,       64'h0004_0003_0002_0001);
      end
    end
    bus.valid_i = 1'b0;
    tick();
    check("t1_w2_mask", 64'(bus.valid_o), 64'hF);
    check("t1_w2_data", bus.data_o,       64'h0008_0007_0006_0005);
    tick();
    check("t1_drained", 64'(bus.valid_o), 64'h0);

    // Partial word via flush
    bus.valid_i = 1'b1;
    bus.data_i  = 16'hAAAA;
    tick();
    bus.data_i  = 16'hBBBB;
    tick();
    bus.valid_i = 1'b0;
    flush       = 1'b1;
    tick();
    flush = 1'b0;
    check("t2_mask", 64'(bus.valid_o), 64'h3);
    check("t2_data", bus.data_o,       64'h0000_0000_BBBB_AAAA);
    tick();
    check("t2_drained", 64'(bus.valid_o), 64'h0);

    // Flush with an empty fill is a no-op
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_empty_flush", 64'(bus.valid_o), 64'h0);
    tick();
    check("t6_empty_flush2", 64'(bus.valid_o), 64'h0);

`ifdef SLINK_PACKER_AUTO_FLUSH_EN
    // Auto-flush after 5 idle cycles: word appears 6 cycles after accept
    af_en       = 1'b1;
    af_cnt      = 6'd5;
    bus.valid_i = 1'b1;
    bus.data_i  = 16'h1234;
    tick();
    bus.valid_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c < 6) begin
        check("t3_early", 64'(bus.valid_o), 64'h0);
      end else begin
        check("t3_mask", 64'(bus.valid_o), 64'h1);
        check("t3_data", bus.data_o,       64'h0000_0000_0000_1234);
      end
    end
    af_en = 1'b0;
    tick();
    check("t3_drained", 64'(bus.valid_o), 64'h0);
`else
    // Without the auto-flush build the config inputs have no effect
    af_en       = 1'b1;
    af_cnt      = 6'd0;
    bus.valid_i = 1'b1;
    bus.data_i  = 16'h1234;
    tick();
    bus.valid_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("t3_no_auto", 64'(bus.valid_o), 64'h0);
    end
    af_en = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_flush_mask", 64'(bus.valid_o), 64'h1);
    check("t3_flush_data", bus.data_o,       64'h0000_0000_0000_1234);
    tick();
`endif

    // Backpressure: first word held, second fills, input stalls
    bus.ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.data_i  = 16'h0100 + 16'(i);
      bus.valid_i = 1'b1;
      #1;
      check("t4_ready", 64'(bus.ready_o), 64'h1);
      tick();
    end
    bus.data_i = 16'h0109;
    #1;
    check("t4_stall",      64'(bus.ready_o), 64'h0);
    check("t4_held_mask",  64'(bus.valid_o), 64'hF);
    check("t4_held_data",  bus.data_o,       64'h0104_0103_0102_0101);
    tick();
    tick();
    check("t4_still_held", bus.data_o,       64'h0104_0103_0102_0101);
    check("t4_still_stall", 64'(bus.ready_o), 64'h0);
    bus.ready_i = 1'b1;
    #1;
    check("t4_release_ready", 64'(bus.ready_o), 64'h1);
    tick();
    check("t4_w2_mask", 64'(bus.valid_o), 64'hF);
    check("t4_w2_data", bus.data_o,       64'h0108_0107_0106_0105);
    bus.data_i = 16'h010A;
    tick();
    bus.data_i = 16'h010B;
    tick();
    bus.data_i = 16'h010C;
    tick();
    bus.valid_i = 1'b0;
    check("t4_gap", 64'(bus.valid_o), 64'h0);
    tick();
    check("t4_w3_mask", 64'(bus.valid_o), 64'hF);
    check("t4_w3_data", bus.data_o,       64'h010C_010B_010A_0109);
    tick();

    // Reset mid-word with a pending output
    bus.ready_i = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      bus.data_i  = 16'h0200 + 16'(i);
      bus.valid_i = 1'b1;
      tick();
    end
    bus.valid_i = 1'b0;
    check("t5_pre_rst", 64'(bus.valid_o), 64'hF);
    rst = 1'b1;
    tick();
    check("t5_rst_valid", 64'(bus.valid_o), 64'h0);
    check("t5_rst_data",  bus.data_o,       64'h0);
    rst = 1'b0;
    #1;
    check("t5_rst_ready", 64'(bus.ready_o), 64'h1);
    bus.ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.data_i  = 16'h0300 + 16'(i);
      bus.valid_i = 1'b1;
      tick();
      if (i == 3) begin
        check("t5_no_stale", 64'(bus.valid_o), 64'h0);
      end
    end
    bus.valid_i = 1'b0;
    tick();
    check("t5_mask", 64'(bus.valid_o), 64'hF);
    check("t5_data", bus.data_o,       64'h0304_0303_0302_0301);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/slink_stream_packer.md
SLINK_STREAM_PACKER -- requirements
Module: slink_stream_packer

Interface
REQ-001 Parameter ElemWidth, default 16, bits per element.
REQ-002 Parameter Width, default 32, elements per output word; the design SHALL support any Width from 2 to 64.
REQ-003 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset; synchronous, active-high.
REQ-005 flush_i  in  1  force emission of a partially filled word.
REQ-006 cfg_auto_flush_en_i  in  1  enables the idle-timeout flush.
REQ-007 cfg_auto_flush_count_i  in  6  idle cycles before an auto-flush.
REQ-008 data_i  in  ElemWidth  input element.
REQ-009 valid_i  in  1  input element valid.
REQ-010 ready_o  out  1  input element accepted when valid_i && ready_o.
REQ-011 data_o  out  Width*ElemWidth  packed word; slot k is at bits [k*ElemWidth +: ElemWidth].
REQ-012 valid_o  out  Width  per-slot valid mask, always contiguous from slot 0; the word is transferred when |valid_o && ready_i.
REQ-013 ready_i  in  1  downstream ready.

Function
REQ-014 The block SHALL hold one fill buffer (Width slots) and one output register.
- Fill count: fill_cnt, 0..Width.
- Output register flag: out_vld.
REQ-015 Accepted element SHALL be written to fill slot fill_cnt, and fill_cnt SHALL increment.
REQ-016 ready_o SHALL be 0 only when fill_cnt == Width and no transfer into the output register occurs this cycle; it SHALL be 1 otherwise.
REQ-017 Emit condition: fill_cnt == Width, OR (flush_i && fill_cnt > 0), OR auto-flush fire.
REQ-018 On emit, when !out_vld or the output is drained in the same cycle:
- the fill buffer SHALL move to the output register;
- valid_o SHALL become the lower fill_cnt bits set;
- unused data slots SHALL be zero.
REQ-019 On emit, when the output register stays occupied, the emit SHALL remain pending and fill SHALL continue until fill_cnt == Width.
REQ-020 An element accepted in the same cycle as a transfer SHALL land in slot 0 of the new fill; no bubble is allowed at full throughput.
REQ-021 Output latency from the last accepted element of a full word SHALL be 1 cycle.
REQ-022 Sustained full-rate input with ready_i=1 SHALL give one word per Width cycles with no input stall.
REQ-023 Once asserted, valid_o and data_o SHALL stay stable until transferred.
REQ-024 flush_i with fill_cnt == 0 SHALL be a no-op; it SHALL never emit an all-zero mask.
REQ-025 The idle counter SHALL increment each cycle with fill_cnt > 0 and no element accepted.
- It SHALL clear on any accept or any emit.
- It SHALL saturate at 63.
REQ-026 Auto-flush SHALL fire when cfg_auto_flush_en_i && fill_cnt > 0 && idle counter == cfg_auto_flush_count_i; count 0 fires on the first idle cycle.
REQ-027 Element order SHALL be preserved across words; no element is dropped or duplicated.

Reset
REQ-028 While rst_i is high, the block SHALL set:
- fill_cnt=0, out_vld=0, idle counter=0;
- valid_o=0, data_o=0, ready_o=0.
REQ-029 Reset mid-word SHALL discard the fill buffer and any pending output; ready_o=1 in the first cycle after rst_i falls.

Configuration
REQ-030 Macro SLINK_PACKER_AUTO_FLUSH_EN.
- Defined: REQ-025/026 are implemented.
- Undefined: the idle counter and auto-flush logic SHALL be absent, and cfg_auto_flush_en_i and cfg_auto_flush_count_i are ignored; emits occur only on full or flush_i.

Verification (Width=4, ElemWidth=16)
REQ-031 Eight elements 0x0001..0x0008 at full rate, ready_i=1 -> two words:
- valid_o=4'hF, data_o=0x0004_0003_0002_0001;
- then data_o=0x0008_0007_0006_0005;
- ready_o stays 1 throughout.
REQ-032 Two elements 0xAAAA,0xBBBB, then flush_i pulse -> next cycle valid_o=4'h3, data_o=0x0000_0000_BBBB_AAAA.
REQ-033 Auto-flush enabled, count=5, one element 0x1234, then idle -> valid_o=4'h1 appears exactly 6 cycles after accept, data slot0=0x1234.
REQ-034 ready_i=0, twelve elements offered:
- first word held in the output register;
- ready_o drops after the eighth accept;
- raising ready_i releases both words in order with the correct data.
REQ-035 rst_i asserted with fill_cnt=2 and out_vld=1 -> next cycle valid_o=0; subsequent elements start at slot 0.
REQ-036 flush_i with empty fill and out_vld=0 -> valid_o stays 0.
